nios_led_out_pio: RTL and testbench
===================================

Name: nios_led_out_pio

Overview:
Avalon-MM slave output PIO that drives board LEDs from the Nios II processor. It is the write-side counterpart of the pushbutton input PIO.
- Software writes a data register, or atomically sets/clears individual bits through separate addresses.
- A per-bit blink mask, paced by a prescaled hardware timer, toggles the selected outputs without CPU involvement.
- The block sits on the system interconnect alongside the other PIOs.

Parameters:
DATA_WIDTH, 8, number of output bits on out_port (1..32)
PRESCALE, 50000, clocks per blink tick (1 ms at 50 MHz); must be >= 1

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
address  input  3  register word address
chipselect  input  1  slave select
write_n  input  1  active-low write strobe; a write occurs when chipselect=1 and write_n=0
writedata  input  32  write data; bits at or above DATA_WIDTH are ignored
readdata  output  32  registered read data, zero-extended
out_port  output  DATA_WIDTH  LED drive

Behaviour:
- Single clock domain (clk). Reset is synchronous and active-high. Reset has priority over a write in the same cycle.
- Reset values: DATA=0, MASK=0, PERIOD=0, phase=0, prescale counter=0, period counter=0, readdata=0, out_port=0.
- Register map (word addresses):
  - 0 DATA: R/W.
  - 1 MASK: R/W, blink enable per bit.
  - 2 PERIOD: R/W, 16 bits, blink half-period in ticks.
  - 3 STATUS: RO; bit0=phase, other bits 0.
  - 4 OUTSET: WO; DATA <= DATA | wd.
  - 5 OUTCLEAR: WO; DATA <= DATA & ~wd.
  - 6, 7: reserved; reads return 0, writes are ignored.
- Reads:
  - No read strobe. Every clock, readdata <= mux(address), so the value is valid one cycle after the address is presented.
  - Reads of 4, 5, 6, 7 return 0.
- Writes take effect on the clock edge that samples them.
- out_port = DATA & ~(MASK & {DATA_WIDTH{phase}}).
  - out_port is combinational from registers, so it changes on the same edge as the register update.
  - Blinking bits go dark during phase=1. A masked bit with DATA=0 stays off.
- Timer when PERIOD != 0:
  - The prescale counter counts 0..PRESCALE-1 and wraps; tick = (count == PRESCALE-1).
  - On a tick, the period counter increments. When it equals PERIOD-1, it wraps to 0 and phase toggles.
  - Phase therefore toggles every PERIOD*PRESCALE clocks.
- Timer when PERIOD == 0: both counters are held at 0 and phase is forced to 0 (blink disabled).
- A write to PERIOD (any value):
  - clears the prescale counter, period counter and phase in that same edge;
  - takes priority over a coincident tick;
  - restarts the blink cycle with a full phase-0 interval.
- A write to MASK does not disturb the timer. A write to DATA, OUTSET or OUTCLEAR does not disturb the timer either.
- OUTSET and OUTCLEAR modify DATA; in the same cycle the timer advances normally.
- Counter widths:
  - prescale counter: $clog2(PRESCALE), minimum 1 bit;
  - period counter: 16 bits.
- Writes where write_n=0 but chipselect=0 are ignored.

Optional Feature:
Macro: LED_PIO_ACTIVE_LOW_EN
- Defined: out_port is the bitwise inverse of the expression above, for active-low LEDs and 7-segment segments. Immediately after reset out_port is all ones. Register reads and the timer are unchanged.
- Undefined: out_port is active-high as specified above.

Test Plan:
All scenarios use DATA_WIDTH=8 and PRESCALE=4.
1. Assert reset 2 cycles, then release.
   -> out_port=0x00. Reading addresses 0..5 gives readdata=0x00000000 each, one cycle after the address.
2. Write addr0=0x1A5, then read addr0.
   -> out_port=0xA5 on the write edge. readdata=0x000000A5 (bit 8 dropped).
3. From DATA=0xA5: write OUTSET=0x0F, then OUTCLEAR=0xA0.
   -> out_port 0xAF, then 0x0F. Reading addr4 returns 0.
4. DATA=0x0F, write MASK=0x03, then write PERIOD=2.
   -> out_port=0x0F for 8 clocks after the PERIOD write, then 0x0C for 8 clocks, and repeats.
   -> STATUS bit0 follows the phase.
5. Mid-phase-1 (out_port=0x0C): write PERIOD=0.
   -> out_port=0x0F on that edge and stays. STATUS=0 persists for 100 clocks.
6. Mid-blink: assert reset in the same cycle as a write of DATA=0xFF.
   -> All registers 0, out_port=0x00, write discarded. With LED_PIO_ACTIVE_LOW_EN defined, out_port=0xFF instead.

Source files
------------

// File: rtl/nios_led_out_pio_if.sv
// nios_led_out_pio_if: Avalon-MM slave bus bundle for the LED output PIO
interface nios_led_out_pio_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    modport master(output address, chipselect, write_n, writedata, input readdata);
    modport slave(input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/nios_led_out_pio.sv
// nios_led_out_pio: Avalon-MM LED output PIO with set/clear access and timer-paced blink; LED_PIO_ACTIVE_LOW_EN inverts out_port
module nios_led_out_pio #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE   = 50000
) (
    input  logic                  clk,
    input  logic                  reset,
    nios_led_out_pio_if.slave     bus,
    output logic [DATA_WIDTH-1:0] out_port
);
    localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

    logic                  wr;
    logic                  period_wr;
    logic                  tick;
    logic                  wrap;
    logic                  phase;
    logic [DATA_WIDTH-1:0] wd;
    logic [DATA_WIDTH-1:0] data;
    logic [DATA_WIDTH-1:0] mask;
    logic [15:0]           period;
    logic [15:0]           tcnt;
    logic [PW-1:0]         pcnt;
    logic [31:0]           rd_mux;

    assign wr        = bus.chipselect & ~bus.write_n;
    assign wd        = bus.writedata[DATA_WIDTH-1:0];
    assign period_wr = wr && bus.address == 3'd2;
    assign tick      = pcnt == PMAX;
    assign wrap      = tick && tcnt == period - 16'd1;

    // Software-visible registers; OUTSET/OUTCLEAR give atomic bit access to DATA
    always_ff @(posedge clk) begin
        if (reset) begin
            data   <= '0;
            mask   <= '0;
            period <= '0;
        end else if (wr) begin
            case (bus.address)
                3'd0: data   <= wd;
                3'd1: mask   <= wd;
                3'd2: period <= bus.writedata[15:0];
                3'd4: data   <= data | wd;
                3'd5: data   <= data & ~wd;
                default: ;
            endcase
        end
    end

    // Blink timer; a PERIOD write restarts a full phase-0 interval, PERIOD=0 parks it
    always_ff @(posedge clk) begin
        if (reset || period_wr || period == 16'd0) begin
            pcnt  <= '0;
            tcnt  <= '0;
            phase <= 1'b0;
        end else begin
            pcnt <= tick ? '0 : pcnt + 1'b1;
            if (tick) begin
                tcnt  <= wrap ? 16'd0 : tcnt + 16'd1;
                phase <= phase ^ wrap;
            end
        end
    end

    // Read mux; write-only and reserved words read as zero
    always_comb begin
        rd_mux = bus.address == 3'd0 ? 32'(data)        :
                 bus.address == 3'd1 ? 32'(mask)        :
                 bus.address == 3'd2 ? {16'd0, period}  :
                 bus.address == 3'd3 ? {31'd0, phase}   : 32'd0;
    end

    // Read data is registered every clock with no read strobe
    always_ff @(posedge clk) begin
        if (reset)
            bus.readdata <= '0;
        else
            bus.readdata <= rd_mux;
    end

`ifdef LED_PIO_ACTIVE_LOW_EN
    assign out_port = ~(data & ~(mask & {DATA_WIDTH{phase}}));
`else
    assign out_port = data & ~(mask & {DATA_WIDTH{phase}});
`endif
endmodule

// File: tb/tb_nios_led_out_pio.sv
// tb_nios_led_out_pio: table-driven and sequence checks with a read-data scoreboard
module tb_nios_led_out_pio;
    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] out_port;
    int         checks = 0;
    int         errors = 0;
    logic [31:0] rd_q[$];

    typedef struct {
        logic [2:0]  a;
        logic        cs;
        logic        wn;
        logic [31:0] wd;
        logic [7:0]  out;
        logic [31:0] rd;
        string       name;
    } vec_t;
    vec_t vecs[$];

    always #5 clk = ~clk;

    nios_led_out_pio_if bus();

    nios_led_out_pio #(.DATA_WIDTH(8), .PRESCALE(4)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .out_port(out_port)
    );

    function automatic logic [7:0] eo(input logic [7:0] v);
`ifdef LED_PIO_ACTIVE_LOW_EN
        return ~v;
`else
        return v;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cycle(input logic [2:0] a, input logic cs, input logic wn, input logic [31:0] wd,
                         input logic rst_in, input logic [7:0] eout, input logic [31:0] erd,
                         input string name);
        bus.address    = a;
        bus.chipselect = cs;
        bus.write_n    = wn;
        bus.writedata  = wd;
        reset          = rst_in;
        rd_q.push_back(erd);
        @(posedge clk);
        #1;
        chk({name, " out_port"}, 32'(out_port), 32'(eo(eout)));
        chk({name, " readdata"}, bus.readdata, rd_q.pop_front());
    endtask

    task automatic blink(input logic [15:0] per, input int n, input logic [31:0] prev);
        int half;
        half = int'(per) * 4;
        cycle(3'd2, 1'b1, 1'b0, 32'(per), 1'b0, 8'h0F, prev, "period_wr");
        for (int k = 1; k <= n; k++)
            cycle(3'd3, 1'b1, 1'b1, 32'd0, 1'b0, ((k / half) % 2) ? 8'h0C : 8'h0F,
                  32'((k - 1) / half % 2), "blink");
    endtask

    initial begin
        vecs.push_back('{3'd0, 1'b1, 1'b1, 32'h0,   8'h00, 32'h0,  "rd0_rst"});
        vecs.push_back('{3'd1, 1'b1, 1'b1, 32'h0,   8'h00, 32'h0,  "rd1_rst"});
        vecs.push_back('{3'd2, 1'b1, 1'b1, 32'h0,   8'h00, 32'h0,  "rd2_rst"});
        vecs.push_back('{3'd3, 1'b1, 1'b1, 32'h0,   8'h00, 32'h0,  "rd3_rst"});
        vecs.push_back('{3'd4, 1'b1, 1'b1, 32'h0,   8'h00, 32'h0,  "rd4_rst"});
        vecs.push_back('{3'd5, 1'b1, 1'b1, 32'h0,   8'h00, 32'h0,  "rd5_rst"});
        vecs.push_back('{3'd0, 1'b1, 1'b0, 32'h1A5, 8'hA5, 32'h0,  "wr_data"});
        vecs.push_back('{3'd0, 1'b1, 1'b1, 32'h0,   8'hA5, 32'hA5, "rd_data"});
        vecs.push_back('{3'd4, 1'b1, 1'b0, 32'h0F,  8'hAF, 32'h0,  "outset"});
        vecs.push_back('{3'd5, 1'b1, 1'b0, 32'hA0,  8'h0F, 32'h0,  "outclear"});
        vecs.push_back('{3'd4, 1'b1, 1'b1, 32'h0,   8'h0F, 32'h0,  "rd_outset"});
        vecs.push_back('{3'd0, 1'b1, 1'b1, 32'h0,   8'h0F, 32'h0F, "rd_data2"});
        vecs.push_back('{3'd0, 1'b0, 1'b0, 32'hFF,  8'h0F, 32'h0F, "wr_no_cs"});
        vecs.push_back('{3'd6, 1'b1, 1'b0, 32'hFF,  8'h0F, 32'h0,  "wr_resv"});
        vecs.push_back('{3'd7, 1'b1, 1'b1, 32'h0,   8'h0F, 32'h0,  "rd_resv"});
        vecs.push_back('{3'd0, 1'b1, 1'b1, 32'h0,   8'h0F, 32'h0F, "rd_data3"});
        vecs.push_back('{3'd1, 1'b1, 1'b0, 32'h03,  8'h0F, 32'h0,  "wr_mask"});
        vecs.push_back('{3'd1, 1'b1, 1'b1, 32'h0,   8'h0F, 32'h03, "rd_mask"});
        vecs.push_back('{3'd2, 1'b1, 1'b1, 32'h0,   8'h0F, 32'h0,  "rd_period"});
        vecs.push_back('{3'd3, 1'b1, 1'b1, 32'h0,   8'h0F, 32'h0,  "rd_status"});

        cycle(3'd0, 1'b0, 1'b1, 32'd0, 1'b1, 8'h00, 32'd0, "reset1");
        cycle(3'd0, 1'b0, 1'b1, 32'd0, 1'b1, 8'h00, 32'd0, "reset2");

        foreach (vecs[i])
            cycle(vecs[i].a, vecs[i].cs, vecs[i].wn, vecs[i].wd, 1'b0, vecs[i].out, vecs[i].rd, vecs[i].name);

        blink(16'd2, 43, 32'd0);
        cycle(3'd2, 1'b1, 1'b0, 32'd0, 1'b0, 8'h0F, 32'd2, "period0");
        for (int i = 0; i < 100; i++)
            cycle(3'd3, 1'b1, 1'b1, 32'd0, 1'b0, 8'h0F, 32'd0, "parked");

        blink(16'd1, 6, 32'd0);
        blink(16'd1, 6, 32'd1);

        cycle(3'd0, 1'b1, 1'b0, 32'hFF, 1'b1, 8'h00, 32'd0, "rst_wr");
        cycle(3'd0, 1'b1, 1'b1, 32'd0, 1'b0, 8'h00, 32'd0, "post_rst0");
        cycle(3'd1, 1'b1, 1'b1, 32'd0, 1'b0, 8'h00, 32'd0, "post_rst1");
        cycle(3'd2, 1'b1, 1'b1, 32'd0, 1'b0, 8'h00, 32'd0, "post_rst2");
        cycle(3'd3, 1'b1, 1'b1, 32'd0, 1'b0, 8'h00, 32'd0, "post_rst3");
        cycle(3'd3, 1'b1, 1'b1, 32'd0, 1'b0, 8'h00, 32'd0, "post_rst4");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
